// File: rtl/loop_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loop_filter_pkg                                                      |
// | Shared types, default widths and fixed-point helpers for the PI      |
// | loop filter.                                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package loop_filter_pkg;

  typedef enum logic [0:0] {
    MODE_ACQ   = 1'b0,
    MODE_TRACK = 1'b1
  } mode_t;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_COEFF_WIDTH = 16;
  localparam int DEF_ACC_WIDTH   = 40;
  localparam int DEF_CNT_WIDTH   = 16;

  // Working width for the helpers; callers must keep ACC_WIDTH+1 below this.
  localparam int CALC_WIDTH = 64;
  typedef logic signed [CALC_WIDTH-1:0] calc_t;

  function automatic calc_t sat_signed(input calc_t value, input int width);
    calc_t hi;
    calc_t lo;
    hi = (calc_t'(1) <<< (width - 1)) - calc_t'(1);
    lo = -hi - calc_t'(1);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Round half up, then arithmetic shift.
  function automatic calc_t round_shift(input calc_t value, input int shift);
    return (value + (calc_t'(1) <<< (shift - 1))) >>> shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pi_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pi_round_sat                                                         |
// | Rounds the PI sum back to the output Q format and clamps it.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pi_round_sat
  import loop_filter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH
) (
  input  logic signed [ACC_WIDTH:0]    i_sum,
  output logic signed [DATA_WIDTH-1:0] o_v,
  output logic                         o_sat
);

  calc_t w_wide;
  calc_t w_rnd;
  calc_t w_clip;

  always_comb begin
    w_wide = calc_t'(i_sum);
    w_rnd  = round_shift(w_wide, COEFF_WIDTH - 1);
    w_clip = sat_signed(w_rnd, DATA_WIDTH);
  end

  assign o_v   = w_clip[DATA_WIDTH-1:0];
  assign o_sat = (w_clip != w_rnd);

endmodule
`default_nettype wire

// File: rtl/loop_filter_pi_gear.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | loop_filter_pi_gear                                                  |
// | Two-stage PI timing loop filter with ACQ/TRACK gear shift, freeze,   |
// | restart, rounding and sticky saturation reporting.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module loop_filter_pi_gear
  import loop_filter_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int COEFF_WIDTH = DEF_COEFF_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_restart,
  input  logic                          i_freeze,
  input  logic signed [COEFF_WIDTH-1:0] i_kp_acq,
  input  logic signed [COEFF_WIDTH-1:0] i_ki_acq,
  input  logic signed [COEFF_WIDTH-1:0] i_kp_trk,
  input  logic signed [COEFF_WIDTH-1:0] i_ki_trk,
  input  logic        [CNT_WIDTH-1:0]   i_acq_len,
  input  logic                          i_e_valid,
  input  logic signed [DATA_WIDTH-1:0]  i_e_in,
  output logic                          o_v_valid,
  output logic signed [DATA_WIDTH-1:0]  o_v_out,
  output logic                          o_track,
  output logic                          o_sat_flag
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
  localparam int SUM_WIDTH  = ACC_WIDTH + 1;

  mode_t                        r_mode;
  logic [CNT_WIDTH-1:0]         r_cnt;
  logic                         r_valid1;
  logic signed [PROD_WIDTH-1:0] r_p_prod;
  logic signed [PROD_WIDTH-1:0] r_i_prod;
  logic signed [ACC_WIDTH-1:0]  r_integ;

  logic signed [COEFF_WIDTH-1:0] w_kp;
  logic signed [COEFF_WIDTH-1:0] w_ki;
  logic signed [PROD_WIDTH-1:0]  w_p_prod;
  logic signed [PROD_WIDTH-1:0]  w_i_prod;
  logic        [CNT_WIDTH:0]     w_cnt_inc;
  logic signed [SUM_WIDTH-1:0]   w_i_sum;
  calc_t                         w_i_clip;
  logic signed [ACC_WIDTH-1:0]   w_i_sat;
  logic                          w_i_ovf;
  logic signed [ACC_WIDTH-1:0]   w_i_use;
  logic signed [SUM_WIDTH-1:0]   w_sum;
  logic signed [DATA_WIDTH-1:0]  w_v;
  logic                          w_v_sat;

  // Stage 1: gains follow the mode in force when the sample is accepted.
  assign w_kp      = (r_mode == MODE_TRACK) ? i_kp_trk : i_kp_acq;
  assign w_ki      = (r_mode == MODE_TRACK) ? i_ki_trk : i_ki_acq;
  assign w_p_prod  = PROD_WIDTH'(w_kp) * PROD_WIDTH'(i_e_in);
  assign w_i_prod  = PROD_WIDTH'(w_ki) * PROD_WIDTH'(i_e_in);
  assign w_cnt_inc = {1'b0, r_cnt} + (CNT_WIDTH + 1)'(1);

  // Stage 2: the output sees the integrator already updated with this sample.
  assign w_i_sum  = SUM_WIDTH'(r_integ) + SUM_WIDTH'(r_i_prod);
  assign w_i_clip = sat_signed(calc_t'(w_i_sum), ACC_WIDTH);
  assign w_i_sat  = w_i_clip[ACC_WIDTH-1:0];
  assign w_i_ovf  = (w_i_clip != calc_t'(w_i_sum));
  assign w_i_use  = i_freeze ? r_integ : w_i_sat;
  assign w_sum    = SUM_WIDTH'(w_i_use) + SUM_WIDTH'(r_p_prod);

  pi_round_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEFF_WIDTH(COEFF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_round (
    .i_sum(w_sum),
    .o_v  (w_v),
    .o_sat(w_v_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= MODE_ACQ;
      r_cnt  <= '0;
    end else if (i_restart) begin
      r_mode <= MODE_ACQ;
      r_cnt  <= '0;
    end else if (r_mode == MODE_ACQ) begin
      if (i_acq_len == '0) begin
        r_mode <= MODE_TRACK;
      end else if (i_e_valid) begin
        r_cnt <= w_cnt_inc[CNT_WIDTH-1:0];
        if (w_cnt_inc >= {1'b0, i_acq_len}) r_mode <= MODE_TRACK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid1   <= 1'b0;
      r_p_prod   <= '0;
      r_i_prod   <= '0;
      r_integ    <= '0;
      o_v_valid  <= 1'b0;
      o_v_out    <= '0;
      o_sat_flag <= 1'b0;
    end else if (i_restart) begin
      r_valid1   <= 1'b0;
      r_integ    <= '0;
      o_v_valid  <= 1'b0;
      o_sat_flag <= 1'b0;
    end else begin
      r_valid1  <= i_e_valid;
      o_v_valid <= r_valid1;
      if (i_e_valid) begin
        r_p_prod <= w_p_prod;
        r_i_prod <= w_i_prod;
      end
      if (r_valid1) begin
        if (!i_freeze) r_integ <= w_i_sat;
        o_v_out <= w_v;
        if (w_v_sat || (w_i_ovf && !i_freeze)) o_sat_flag <= 1'b1;
      end
    end
  end

  assign o_track = (r_mode == MODE_TRACK);

endmodule
`default_nettype wire

// File: tb/tb_loop_filter_pi_gear.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_loop_filter_pi_gear                                               |
// | Scoreboard bench: arithmetic reference model vs. loop_filter_pi_gear.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_loop_filter_pi_gear;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 40;
  localparam int NW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 restart = 1'b0;
  logic                 freeze = 1'b0;
  logic signed [CW-1:0] kp_acq = '0;
  logic signed [CW-1:0] ki_acq = '0;
  logic signed [CW-1:0] kp_trk = '0;
  logic signed [CW-1:0] ki_trk = '0;
  logic [NW-1:0]        acq_len = '0;
  logic                 e_valid = 1'b0;
  logic signed [DW-1:0] e_in = '0;
  logic                 v_valid;
  logic signed [DW-1:0] v_out;
  logic                 track;
  logic                 sat_flag;

  loop_filter_pi_gear #(
    .DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ACC_WIDTH(AW), .CNT_WIDTH(NW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_restart(restart), .i_freeze(freeze),
    .i_kp_acq(kp_acq), .i_ki_acq(ki_acq), .i_kp_trk(kp_trk), .i_ki_trk(ki_trk),
    .i_acq_len(acq_len), .i_e_valid(e_valid), .i_e_in(e_in),
    .o_v_valid(v_valid), .o_v_out(v_out), .o_track(track), .o_sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int v;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  longint m_integ = 0;
  int     m_cnt   = 0;
  bit     m_sat   = 1'b0;
  bit     pend    = 1'b0;
  longint pend_p, pend_i;
  int     pend_cyc;
  int     last_v  = 0;

  localparam longint AMAX = (longint'(1) <<< (AW - 1)) - 1;
  localparam longint AMIN = -AMAX - 1;
  localparam longint VMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint VMIN = -VMAX - 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Completes a sample once the freeze level its second stage sees is known.
  task automatic finish_sample(input bit frz);
    longint s, v, inew;
    exp_t   t;
    if (!frz) begin
      inew = m_integ + pend_i;
      if (inew > AMAX) begin inew = AMAX; m_sat = 1'b1; end
      if (inew < AMIN) begin inew = AMIN; m_sat = 1'b1; end
      m_integ = inew;
    end
    s = pend_p + m_integ;
    v = (s + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
    if (v > VMAX) begin v = VMAX; m_sat = 1'b1; end
    if (v < VMIN) begin v = VMIN; m_sat = 1'b1; end
    t.v   = int'(v);
    t.cyc = pend_cyc;
    sb.push_back(t);
  endtask

  task automatic drive(input bit vld, input int e, input bit rst_p, input bit frz);
    longint kp, ki, ee;
    bit     trk;
    restart = rst_p;
    freeze  = frz;
    e_valid = vld;
    e_in    = DW'(e);
    if (rst_p) begin
      m_integ = 0;
      m_cnt   = 0;
      m_sat   = 1'b0;
    end else if (pend) begin
      finish_sample(frz);
    end
    pend = 1'b0;
    if (vld && !rst_p) begin
      trk = (m_cnt >= int'(acq_len));
      kp  = trk ? kp_trk : kp_acq;
      ki  = trk ? ki_trk : ki_acq;
      if (!trk) m_cnt++;
      ee       = e_in;
      pend_p   = kp * ee;
      pend_i   = ki * ee;
      pend     = 1'b1;
      pend_cyc = cyc + 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    drive(1'b0, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic drain(input bit frz);
    for (int i = 0; i < 12 && (pend || sb.size() != 0); i++) drive(1'b0, 0, 1'b0, frz);
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every v_valid strobe must match the oldest expected response.
  exp_t mon_x;
  always @(negedge clk) begin
    if (v_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_v_valid: v_out %0d at cycle %0d, none expected", v_out, cyc);
      end else begin
        mon_x = sb.pop_front();
        last_v = mon_x.v;
        if (v_out !== DW'(mon_x.v) || cyc != mon_x.cyc) begin
          n_err++;
          $display("FAIL v_out: got %0d at cycle %0d, expected %0d at cycle %0d",
                   v_out, cyc, mon_x.v, mon_x.cyc);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_v_valid", v_valid, 0);
    check("rst_v_out", v_out, 0);
    check("rst_track", track, 0);
    check("rst_sat_flag", sat_flag, 0);
    rst_n = 1'b1;

    // Basic PI
    acq_len = 16'd100; kp_acq = 16'h0020; ki_acq = 16'h0004;
    kp_trk = 16'h1234; ki_trk = 16'h0777;
    drive(1'b1, 32'h4000, 1'b0, 1'b0);
    drive(1'b1, 32'h4000, 1'b0, 1'b0);
    drain(1'b0);
    check("basic_last_v", last_v, 32'h14);
    check("basic_track", track, 0);

    // Gear shift after three accepted samples
    do_restart();
    acq_len = 16'd3; kp_acq = 16'h0100; kp_trk = 16'h0020; ki_acq = '0; ki_trk = '0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h4000, 1'b0, 1'b0);
      if (i == 1) check("gear_track_before", track, 0);
      if (i == 2) check("gear_track_after", track, 1);
    end
    drain(1'b0);
    check("gear_last_v", last_v, 32'h10);

    // Output saturation: (-1)*(-1) must clamp, not wrap
    do_restart();
    acq_len = 16'd100; kp_acq = 16'h8000; ki_acq = '0;
    drive(1'b1, 32'h8000, 1'b0, 1'b0);
    drain(1'b0);
    check("osat_v", last_v, 32'h7FFF);
    check("osat_flag", sat_flag, 1);
    drive(1'b1, 0, 1'b0, 1'b0);
    drain(1'b0);
    check("osat_flag_sticky", sat_flag, 1);

    // Integrator saturation
    do_restart();
    acq_len = 16'd1000; kp_acq = '0; ki_acq = 16'h7FFF;
    for (int i = 0; i < 600; i++) drive(1'b1, 32'h7FFF, 1'b0, 1'b0);
    drain(1'b0);
    check("isat_v", last_v, 32'h7FFF);
    check("isat_flag", sat_flag, 1);
    for (int i = 0; i < 20; i++) drive(1'b1, -32'sh7FFF, 1'b0, 1'b0);
    drain(1'b0);
    check("isat_no_wrap", last_v, 32'h7FFF);

    // Freeze, then restart together with a sample
    do_restart();
    acq_len = 16'd100; kp_acq = 16'h0020; ki_acq = 16'h0004;
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h4000, 1'b0, 1'b0);
    drain(1'b0);
    drive(1'b0, 0, 1'b0, 1'b1);
    drive(1'b1, 0, 1'b0, 1'b1);
    drive(1'b1, 0, 1'b0, 1'b1);
    drive(1'b1, 32'h4000, 1'b0, 1'b1);
    drive(1'b1, 32'h4000, 1'b0, 1'b1);
    drain(1'b1);
    check("freeze_hold_v", last_v, 32'h18);
    drive(1'b1, 32'h4000, 1'b1, 1'b0);
    check("restart_v_hold", v_out, last_v);
    drive(1'b1, 32'h4000, 1'b0, 1'b0);
    drain(1'b0);
    check("restart_v", last_v, 32'h12);
    check("restart_track", track, 0);
    check("restart_sat_flag", sat_flag, 0);

    // Async reset with samples in flight
    do_restart();
    acq_len = 16'd1; kp_acq = 16'h8000; ki_acq = '0; kp_trk = 16'h0020; ki_trk = '0;
    drive(1'b1, 32'h8000, 1'b0, 1'b0);
    drive(1'b1, 32'h4000, 1'b0, 1'b0);
    e_valid = 1'b0;
    rst_n = 1'b0;
    pend = 1'b0; sb.delete(); m_integ = 0; m_cnt = 0; m_sat = 1'b0;
    #1;
    check("arst_v_valid", v_valid, 0);
    check("arst_v_out", v_out, 0);
    check("arst_track", track, 0);
    check("arst_sat_flag", sat_flag, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 1'b0, 1'b0);
    check("arst_track_after", track, 0);

    // acq_len = 0 goes straight to TRACK
    acq_len = '0;
    do_restart();
    check("zero_len_track", track, 1);

    // Randomized traffic
    acq_len = NW'($urandom_range(1, 20));
    kp_acq = CW'($urandom); ki_acq = CW'($urandom);
    kp_trk = CW'($urandom); ki_trk = CW'($urandom);
    do_restart();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        ki_acq = CW'($urandom); ki_trk = CW'($urandom);
        kp_acq = CW'($urandom >> 4); kp_trk = CW'($urandom >> 4);
      end
      drive(($urandom_range(0, 9) < 7), int'($urandom), ($urandom_range(0, 79) == 0),
            ($urandom_range(0, 4) == 0));
    end
    drain(1'b0);
    check("rand_sat_flag", sat_flag, m_sat);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/loop_filter_pi_gear.md
Name: loop_filter_pi_gear

Overview:
Second-generation PI loop filter for the ZCTED symbol-timing recovery loop. It sits between the zero stuffer and the NCO/interpolator control. It filters the timing error e[n] into the control word v[n], with parametrised widths and run-time programmable gains. It adds a two-mode gear-shift FSM (acquisition, then tracking gains), integrator freeze, restart, rounding, and saturation with overflow reporting.

Parameters:
DATA_WIDTH, 16, width of e_in and v_out, signed Q1.(DATA_WIDTH-1)
COEFF_WIDTH, 16, width of gain inputs, signed Q1.(COEFF_WIDTH-1)
ACC_WIDTH, 40, integrator width; same scaling as the product (fraction DATA_WIDTH+COEFF_WIDTH-2); must be >= DATA_WIDTH+COEFF_WIDTH
CNT_WIDTH, 16, width of acquisition sample counter and acq_len

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
restart  in  1  sync pulse: flush pipeline, clear integrator/counter/sat_flag, enter ACQ
freeze  in  1  level: integrator holds, proportional path still active
kp_acq  in  COEFF_WIDTH  proportional gain, ACQ mode
ki_acq  in  COEFF_WIDTH  integral gain, ACQ mode
kp_trk  in  COEFF_WIDTH  proportional gain, TRACK mode
ki_trk  in  COEFF_WIDTH  integral gain, TRACK mode
acq_len  in  CNT_WIDTH  number of accepted samples spent in ACQ
e_valid  in  1  e_in qualifier (zero-stuffer valid)
e_in  in  DATA_WIDTH  signed timing error
v_valid  out  1  v_out update strobe
v_out  out  DATA_WIDTH  signed control word, holds between strobes
track  out  1  0 = ACQ, 1 = TRACK
sat_flag  out  1  sticky: output or integrator saturated since reset/restart

Behaviour:
- Single clock. Async active-low reset clears all state.
- Reset values: v_out=0, v_valid=0, track=0, sat_flag=0, integrator=0, counter=0, FSM=ACQ.
- Transfer function: I[n] = sat_acc(I[n-1] + Ki*e[n]) and v[n] = sat_out(round(Kp*e[n] + I[n])).
- The output uses the integrator value after it has been updated with the current sample.
- Pipeline: 2 cycles.
  - Stage 1 (cycle of e_valid): select gains by current mode; register Kp*e and Ki*e, both full-precision DATA_WIDTH+COEFF_WIDTH; register valid.
  - Stage 2: update the integrator; register v_out and assert v_valid.
  - v_valid is high exactly one cycle per accepted sample, 2 cycles after e_valid. Back-to-back e_valid is supported at full rate.
- Arithmetic:
  - Products are sign-extended to ACC_WIDTH before adding.
  - sat_acc clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; the integrator never wraps.
  - Sum is formed at ACC_WIDTH+1 bits.
  - round adds 2^(COEFF_WIDTH-2), then arithmetic right shift by COEFF_WIDTH-1 (round half up).
  - sat_out clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Any clamp event sets sat_flag.
- freeze=1 at stage 2: the integrator keeps its value; v = round(Kp*e + I_held). freeze does not affect the counter or FSM.
- FSM ACQ -> TRACK:
  - In ACQ, each accepted sample (e_valid at stage 1) increments the counter.
  - The sample that brings count to acq_len uses ACQ gains; the following sample uses TRACK gains. track rises the cycle after that accepted sample.
  - acq_len=0: enter TRACK the cycle after reset/restart.
  - TRACK is absorbing until restart or reset.
  - Gains are sampled at stage 1. Changing gain inputs mid-stream takes effect on the next accepted sample.
- restart is priority over everything:
  - Next cycle: integrator=0, counter=0, FSM=ACQ, track=0, sat_flag=0, stage-1 valid cleared, v_valid=0.
  - A sample presented with restart is discarded. v_out holds its last value.
- Reset mid-operation: immediate async clear. No v_valid is produced for in-flight samples.
- Default scaling check: Kp=0x0020, Ki=0x0004, e=0x4000 gives product terms 2^19 and 2^16, so v=0x0012.

Decomposition:
- Package loop_filter_pkg holds:
  - mode enum {MODE_ACQ, MODE_TRACK};
  - default width localparams;
  - functions sat_signed(value, width) and round_shift(value, shift).
- One sub-module, pi_round_sat: combinational round/shift/clamp from ACC_WIDTH+1 to DATA_WIDTH, with a sat output. It is instantiated once in stage 2.
- Integrator saturation is done inline using the package function.

Test Plan:
- Basic PI: reset, acq_len=100, kp_acq=0x0020, ki_acq=0x0004, two samples e=0x4000 -> v_out 0x0012 then 0x0014, each v_valid exactly 2 cycles after e_valid; track=0.
- Gear shift: acq_len=3, kp_acq=0x0100, kp_trk=0x0020, ki=0, e=0x4000 x5 back-to-back -> v_out 0x0080 x3 then 0x0010 x2; track rises the cycle after the 3rd accepted sample.
- Output saturation: kp=0x8000, ki=0, e=0x8000 -> v_out=0x7FFF (not 0x8000), sat_flag=1 and stays 1.
- Integrator saturation: ki=0x7FFF, kp=0, e=0x7FFF x600 -> v_out climbs monotonically to 0x7FFF and stays there; never goes negative; sat_flag=1.
- Freeze/restart: accumulate 4 samples, freeze=1 with e=0 -> v_out constant. Then restart together with e_valid -> no v_valid for that sample; the next sample (e=0x4000, Ki=0x0004, Kp=0x0020) gives 0x0012; track=0, sat_flag=0.
- Async reset mid-stream: deassert rst_n between e_valid and v_valid -> no v_valid, all outputs 0, FSM in ACQ after release.
